// File: rtl/mips_pkg.sv
// Shared encodings for the parameterised 5-stage MIPS-style pipeline:
// opcodes, instruction classes, field positions and forwarding selects.
package mips_pkg;

  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 26;
  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int RD_MSB  = 15;
  localparam int RD_LSB  = 11;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  localparam logic [5:0] OP_ADD   = 6'h00;
  localparam logic [5:0] OP_SUB   = 6'h01;
  localparam logic [5:0] OP_AND   = 6'h02;
  localparam logic [5:0] OP_OR    = 6'h03;
  localparam logic [5:0] OP_SLT   = 6'h04;
  localparam logic [5:0] OP_MUL   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h08;
  localparam logic [5:0] OP_SW    = 6'h09;
  localparam logic [5:0] OP_ADDI  = 6'h0a;
  localparam logic [5:0] OP_SUBI  = 6'h0b;
  localparam logic [5:0] OP_SLTI  = 6'h0c;
  localparam logic [5:0] OP_BNEQZ = 6'h0d;
  localparam logic [5:0] OP_BEQZ  = 6'h0e;
  localparam logic [5:0] OP_HLT   = 6'h3f;

  typedef enum logic [2:0] {
    RR_ALU = 3'd0,
    RM_ALU = 3'd1,
    LOAD   = 3'd2,
    STORE  = 3'd3,
    BRANCH = 3'd4,
    HALT   = 3'd5
  } itype_e;

  typedef enum logic [1:0] {
    FWD_REG   = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_e;

  // Unknown opcodes are classed as HALT so they stop the machine cleanly.
  function automatic itype_e op_type(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: return RR_ALU;
      OP_ADDI, OP_SUBI, OP_SLTI:                     return RM_ALU;
      OP_LW:                                         return LOAD;
      OP_SW:                                         return STORE;
      OP_BEQZ, OP_BNEQZ:                             return BRANCH;
      default:                                       return HALT;
    endcase
  endfunction

endpackage

// File: rtl/mips_hazard_unit.sv
// Operand forwarding selection for EX and load-use stall detection for ID.
module mips_hazard_unit
  import mips_pkg::*;
(
  input  logic       id_vld,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic       ex_vld,
  input  itype_e     ex_type,
  input  logic [4:0] ex_rs,
  input  logic [4:0] ex_rt,
  input  logic       exm_fwd_ok,
  input  logic [4:0] exm_dest,
  input  logic       wb_we,
  input  logic [4:0] wb_dest,
  output fwd_sel_e   fwd_a,
  output fwd_sel_e   fwd_b,
  output logic       load_use_stall
);

  always_comb begin
    fwd_a = FWD_REG;
    fwd_b = FWD_REG;
    if (ex_rs != 5'd0) begin
      if (exm_fwd_ok && exm_dest == ex_rs)  fwd_a = FWD_EXMEM;
      else if (wb_we && wb_dest == ex_rs)   fwd_a = FWD_MEMWB;
    end
    if (ex_rt != 5'd0) begin
      if (exm_fwd_ok && exm_dest == ex_rt)  fwd_b = FWD_EXMEM;
      else if (wb_we && wb_dest == ex_rt)   fwd_b = FWD_MEMWB;
    end
  end

  always_comb begin
    load_use_stall = 1'b0;
    if (id_vld && ex_vld && ex_type == LOAD && ex_rt != 5'd0) begin
      load_use_stall = (id_use_rs && id_rs == ex_rt) || (id_use_rt && id_rt == ex_rt);
    end
  end

endmodule

// File: rtl/pipe_mips_param.sv
// Parameterised 5-stage (IF/ID/EX/MEM/WB) MIPS-style pipeline with a unified
// word-addressed memory, preload port, debug register read and halt tracking.
module pipe_mips_param
  import mips_pkg::*;
#(
  parameter int  XLEN      = 32,
  parameter int  NREG      = 32,
  parameter int  MEM_DEPTH = 1024,
  localparam int AW        = $clog2(MEM_DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            ld_en,
  input  logic [AW-1:0]   ld_addr,
  input  logic [31:0]     ld_data,
  input  logic [4:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data,
  output logic            running,
  output logic            halted,
  output logic [31:0]     retired
);

  logic [31:0]     mem_q [MEM_DEPTH];
  logic [XLEN-1:0] rf_q  [NREG];

  logic [AW-1:0] pc_q, pc_d;
  logic          running_q, running_d, halted_q, halted_d, stop_q, stop_d;
  logic [31:0]   retired_q, retired_d;

  logic          ifid_vld_q, ifid_vld_d;
  logic [31:0]   ifid_ir_q, ifid_ir_d;
  logic [AW-1:0] ifid_npc_q, ifid_npc_d;

  logic            idex_vld_q, idex_vld_d, idex_we_q, idex_we_d;
  itype_e          idex_type_q, idex_type_d;
  logic [5:0]      idex_op_q, idex_op_d;
  logic [XLEN-1:0] idex_a_q, idex_a_d, idex_b_q, idex_b_d, idex_imm_q, idex_imm_d;
  logic [4:0]      idex_rs_q, idex_rs_d, idex_rt_q, idex_rt_d, idex_dest_q, idex_dest_d;
  logic [AW-1:0]   idex_npc_q, idex_npc_d;

  logic            exm_vld_q, exm_vld_d, exm_we_q, exm_we_d;
  itype_e          exm_type_q, exm_type_d;
  logic [XLEN-1:0] exm_alu_q, exm_alu_d, exm_b_q, exm_b_d;
  logic [4:0]      exm_dest_q, exm_dest_d;

  logic            wb_vld_q, wb_vld_d, wb_we_q, wb_we_d;
  itype_e          wb_type_q, wb_type_d;
  logic [XLEN-1:0] wb_val_q, wb_val_d;
  logic [4:0]      wb_dest_q, wb_dest_d;

  logic            start_ok, fetch_en, id_halt, stall, wb_rf_we, wb_halt;
  logic            id_use_rs, id_use_rt, ex_taken, mem_we, ld_we;
  logic [4:0]      id_rd;
  logic [XLEN-1:0] ex_a, ex_b;
  logic [AW-1:0]   ex_target, mem_addr;
  logic [31:0]     mem_rdata;
  fwd_sel_e        fwd_a, fwd_b;

  function automatic logic [XLEN-1:0] slt_s(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    return {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
  endfunction

  assign dbg_data = rf_q[dbg_addr];
  assign running  = running_q;
  assign halted   = halted_q;
  assign retired  = retired_q;

  assign start_ok = start && !running_q && !halted_q;
  assign fetch_en = running_q && !stop_q;
  assign wb_rf_we = wb_vld_q && wb_we_q;
  assign wb_halt  = wb_vld_q && wb_type_q == HALT;
  assign ld_we    = ld_en && !running_q && !rst;

  // ID: decode and register read, with same-cycle WB write-through
  always_comb begin
    idex_op_d   = ifid_ir_q[OP_MSB:OP_LSB];
    idex_rs_d   = ifid_ir_q[RS_MSB:RS_LSB];
    idex_rt_d   = ifid_ir_q[RT_MSB:RT_LSB];
    id_rd       = ifid_ir_q[RD_MSB:RD_LSB];
    idex_imm_d  = XLEN'($signed(ifid_ir_q[IMM_MSB:IMM_LSB]));
    idex_type_d = op_type(idex_op_d);
    idex_npc_d  = ifid_npc_q;
    id_use_rs   = idex_type_d != HALT;
    id_use_rt   = idex_type_d == RR_ALU || idex_type_d == STORE;
    idex_dest_d = (idex_type_d == RR_ALU) ? id_rd : idex_rt_d;
    idex_we_d   = (idex_type_d == RR_ALU || idex_type_d == RM_ALU || idex_type_d == LOAD)
                  && idex_dest_d != 5'd0;
    if (idex_rs_d == 5'd0)                         idex_a_d = '0;
    else if (wb_rf_we && wb_dest_q == idex_rs_d)   idex_a_d = wb_val_q;
    else                                           idex_a_d = rf_q[idex_rs_d];
    if (idex_rt_d == 5'd0)                         idex_b_d = '0;
    else if (wb_rf_we && wb_dest_q == idex_rt_d)   idex_b_d = wb_val_q;
    else                                           idex_b_d = rf_q[idex_rt_d];
    id_halt = ifid_vld_q && idex_type_d == HALT;
  end

  mips_hazard_unit u_hazard (
    .id_vld         (ifid_vld_q),
    .id_rs          (idex_rs_d),
    .id_rt          (idex_rt_d),
    .id_use_rs      (id_use_rs),
    .id_use_rt      (id_use_rt),
    .ex_vld         (idex_vld_q),
    .ex_type        (idex_type_q),
    .ex_rs          (idex_rs_q),
    .ex_rt          (idex_rt_q),
    .exm_fwd_ok     (exm_vld_q && exm_we_q && exm_type_q != LOAD),
    .exm_dest       (exm_dest_q),
    .wb_we          (wb_rf_we),
    .wb_dest        (wb_dest_q),
    .fwd_a          (fwd_a),
    .fwd_b          (fwd_b),
    .load_use_stall (stall)
  );

  // EX: forwarded operands, ALU and branch resolution
  always_comb begin
    case (fwd_a)
      FWD_EXMEM: ex_a = exm_alu_q;
      FWD_MEMWB: ex_a = wb_val_q;
      default:   ex_a = idex_a_q;
    endcase
    case (fwd_b)
      FWD_EXMEM: ex_b = exm_alu_q;
      FWD_MEMWB: ex_b = wb_val_q;
      default:   ex_b = idex_b_q;
    endcase
    case (idex_op_q)
      OP_ADD:               exm_alu_d = ex_a + ex_b;
      OP_SUB:               exm_alu_d = ex_a - ex_b;
      OP_AND:               exm_alu_d = ex_a & ex_b;
      OP_OR:                exm_alu_d = ex_a | ex_b;
      OP_SLT:               exm_alu_d = slt_s(ex_a, ex_b);
      OP_MUL:               exm_alu_d = ex_a * ex_b;
      OP_ADDI, OP_LW, OP_SW: exm_alu_d = ex_a + idex_imm_q;
      OP_SUBI:              exm_alu_d = ex_a - idex_imm_q;
      OP_SLTI:              exm_alu_d = slt_s(ex_a, idex_imm_q);
      default:              exm_alu_d = '0;
    endcase
    ex_taken   = idex_vld_q && idex_type_q == BRANCH &&
                 ((idex_op_q == OP_BEQZ) ? (ex_a == '0) : (ex_a != '0));
    ex_target  = idex_npc_q + idex_imm_q[AW-1:0];
    exm_b_d    = ex_b;
    exm_type_d = idex_type_q;
    exm_dest_d = idex_dest_q;
    exm_we_d   = idex_we_q;
  end

  // MEM: a load sees memory as it was before this cycle's store
  always_comb begin
    mem_addr  = exm_alu_q[AW-1:0];
    mem_rdata = mem_q[mem_addr];
    mem_we    = exm_vld_q && exm_type_q == STORE && !rst;
    wb_val_d  = (exm_type_q == LOAD) ? XLEN'(mem_rdata) : exm_alu_q;
    wb_type_d = exm_type_q;
    wb_dest_d = exm_dest_q;
    wb_we_d   = exm_we_q;
  end

  // Control: fetch sequencing, flush, stall and run state
  always_comb begin
    pc_d      = pc_q;
    stop_d    = stop_q;
    if (start_ok) begin
      pc_d   = '0;
      stop_d = 1'b0;
    end else if (ex_taken) begin
      pc_d = ex_target;
    end else if (fetch_en && !stall && !id_halt) begin
      pc_d = pc_q + AW'(1);
    end
    if (!start_ok && id_halt && !ex_taken) stop_d = 1'b1;

    if (ex_taken)   ifid_vld_d = 1'b0;
    else if (stall) ifid_vld_d = ifid_vld_q;
    else            ifid_vld_d = fetch_en && !id_halt;
    ifid_ir_d  = stall ? ifid_ir_q  : mem_q[pc_q];
    ifid_npc_d = stall ? ifid_npc_q : pc_q + AW'(1);

    idex_vld_d = ifid_vld_q && !stall && !ex_taken;
    exm_vld_d  = idex_vld_q;
    wb_vld_d   = exm_vld_q;
    running_d  = start_ok ? 1'b1 : (wb_halt ? 1'b0 : running_q);
    halted_d   = halted_q || wb_halt;
    retired_d  = retired_q + 32'(wb_vld_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= '0;
      stop_q     <= 1'b0;
      running_q  <= 1'b0;
      halted_q   <= 1'b0;
      retired_q  <= '0;
      ifid_vld_q <= 1'b0;
      idex_vld_q <= 1'b0;
      exm_vld_q  <= 1'b0;
      wb_vld_q   <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      stop_q     <= stop_d;
      running_q  <= running_d;
      halted_q   <= halted_d;
      retired_q  <= retired_d;
      ifid_vld_q <= ifid_vld_d;
      idex_vld_q <= idex_vld_d;
      exm_vld_q  <= exm_vld_d;
      wb_vld_q   <= wb_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    ifid_ir_q   <= ifid_ir_d;
    ifid_npc_q  <= ifid_npc_d;
    idex_type_q <= idex_type_d;
    idex_op_q   <= idex_op_d;
    idex_a_q    <= idex_a_d;
    idex_b_q    <= idex_b_d;
    idex_imm_q  <= idex_imm_d;
    idex_rs_q   <= idex_rs_d;
    idex_rt_q   <= idex_rt_d;
    idex_dest_q <= idex_dest_d;
    idex_we_q   <= idex_we_d;
    idex_npc_q  <= idex_npc_d;
    exm_type_q  <= exm_type_d;
    exm_alu_q   <= exm_alu_d;
    exm_b_q     <= exm_b_d;
    exm_dest_q  <= exm_dest_d;
    exm_we_q    <= exm_we_d;
    wb_type_q   <= wb_type_d;
    wb_val_q    <= wb_val_d;
    wb_dest_q   <= wb_dest_d;
    wb_we_q     <= wb_we_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (wb_rf_we) begin
      rf_q[wb_dest_q] <= wb_val_q;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we)     mem_q[mem_addr] <= 32'(exm_b_q);
    else if (ld_we) mem_q[ld_addr]  <= ld_data;
  end

endmodule

// File: tb/tb_pipe_mips_param.sv
// Scoreboard bench for pipe_mips_param: programs are preloaded, expected register
// values queued, and compared through the debug port once the core halts.
module tb_pipe_mips_param;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, ld_en;
  logic [9:0]  ld_addr;
  logic [31:0] ld_data;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data, retired, retired16;
  logic [15:0] dbg_data16;
  logic        running, halted, running16, halted16;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    bit          is16;
    logic [4:0]  r;
    logic [31:0] exp;
  } sb_t;
  sb_t sb[$];

  always #5 clk = ~clk;

  pipe_mips_param dut (
    .clk(clk), .rst(rst), .start(start), .ld_en(ld_en), .ld_addr(ld_addr),
    .ld_data(ld_data), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .running(running), .halted(halted), .retired(retired)
  );

  pipe_mips_param #(.XLEN(16)) dut16 (
    .clk(clk), .rst(rst), .start(start), .ld_en(ld_en), .ld_addr(ld_addr),
    .ld_data(ld_data), .dbg_addr(dbg_addr), .dbg_data(dbg_data16),
    .running(running16), .halted(halted16), .retired(retired16)
  );

  function automatic logic [31:0] enc_r(logic [5:0] op, logic [4:0] rd, logic [4:0] rs, logic [4:0] rt);
    return {op, rs, rt, rd, 11'd0};
  endfunction

  // Argument order: opcode, rt (destination / store source), rs (base), immediate
  function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rt, logic [4:0] rs, int imm);
    logic [15:0] i16;
    i16 = 16'(imm);
    return {op, rs, rt, i16};
  endfunction

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1; start = 1'b0; ld_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic load(input int a, input logic [31:0] w);
    ld_en = 1'b1; ld_addr = 10'(a); ld_data = w;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic expect_reg(input string n, input bit is16, input int r, input logic [31:0] v);
    sb_t e;
    e.name = n; e.is16 = is16; e.r = 5'(r); e.exp = v;
    sb.push_back(e);
  endtask

  task automatic run(input bit use16, input int bound, output int cyc);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(use16 ? halted16 : halted) && cyc < bound) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic drain_sb;
    sb_t e;
    logic [31:0] act;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      dbg_addr = e.r;
      #1;
      act = e.is16 ? {16'd0, dbg_data16} : dbg_data;
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h want %h", e.name, act, e.exp);
      end
    end
  endtask

  task automatic test_reset;
    do_reset;
    dbg_addr = 5'd3;
    #1;
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running: got %b want 0", running); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", halted); end
    checks++; if (retired !== 32'd0) begin errors++; $display("FAIL reset_retired: got %0d want 0", retired); end
    checks++; if (dbg_data !== 32'd0) begin errors++; $display("FAIL reset_reg3: got %h want 0", dbg_data); end
  endtask

  task automatic test_back_to_back;
    int cyc;
    do_reset;
    load(0, enc_i(OP_ADDI, 1, 0, 10));
    load(1, enc_i(OP_ADDI, 2, 0, 20));
    load(2, enc_r(OP_ADD, 3, 1, 2));
    load(3, {OP_HLT, 26'd0});
    expect_reg("b2b_r1", 0, 1, 32'd10);
    expect_reg("b2b_r2", 0, 2, 32'd20);
    expect_reg("b2b_r3", 0, 3, 32'd30);
    run(0, 200, cyc);
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL b2b_halted: got %b want 1", halted); end
    checks++; if (cyc !== 8) begin errors++; $display("FAIL b2b_cycles: got %0d want 8", cyc); end
    checks++; if (retired !== 32'd4) begin errors++; $display("FAIL b2b_retired: got %0d want 4", retired); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL b2b_running: got %b want 0", running); end
    drain_sb;
    // start after halt must not restart the program
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (retired !== 32'd4) begin errors++; $display("FAIL start_when_halted: retired %0d want 4", retired); end
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halted_sticky: got %b want 1", halted); end
  endtask

  task automatic test_load_use;
    int cyc;
    do_reset;
    load(120, 32'd85);
    load(0, enc_i(OP_ADDI, 1, 0, 120));
    load(1, enc_i(OP_LW, 2, 1, 0));
    load(2, enc_i(OP_ADDI, 3, 2, 45));
    load(3, enc_i(OP_SW, 3, 1, 1));
    load(4, enc_i(OP_LW, 4, 1, 1));
    load(5, {OP_HLT, 26'd0});
    expect_reg("lu_r2", 0, 2, 32'd85);
    expect_reg("lu_r3", 0, 3, 32'd130);
    expect_reg("lu_mem121", 0, 4, 32'd130);
    run(0, 200, cyc);
    checks++; if (cyc !== 11) begin errors++; $display("FAIL lu_cycles: got %0d want 11", cyc); end
    checks++; if (retired !== 32'd6) begin errors++; $display("FAIL lu_retired: got %0d want 6", retired); end
    drain_sb;
  endtask

  task automatic test_arith;
    int cyc;
    do_reset;
    load(200, 32'h7FFF_FFFF);
    load(0, enc_i(OP_ADDI, 1, 0, -1));
    load(1, enc_i(OP_SLTI, 2, 1, 0));
    load(2, enc_i(OP_LW, 3, 0, 200));
    load(3, enc_i(OP_ADDI, 4, 0, 1));
    load(4, enc_r(OP_ADD, 5, 3, 4));
    load(5, enc_r(OP_SLT, 6, 5, 0));
    load(6, enc_r(OP_SUB, 7, 0, 4));
    load(7, enc_r(OP_AND, 8, 3, 1));
    load(8, enc_r(OP_OR, 9, 5, 4));
    load(9, {OP_HLT, 26'd0});
    expect_reg("slti_neg", 0, 2, 32'd1);
    expect_reg("add_ovf", 0, 5, 32'h8000_0000);
    expect_reg("slt_neg", 0, 6, 32'd1);
    expect_reg("sub_wrap", 0, 7, 32'hFFFF_FFFF);
    expect_reg("and", 0, 8, 32'h7FFF_FFFF);
    expect_reg("or", 0, 9, 32'h8000_0001);
    run(0, 200, cyc);
    checks++; if (cyc !== 14) begin errors++; $display("FAIL arith_cycles: got %0d want 14", cyc); end
    checks++; if (retired !== 32'd10) begin errors++; $display("FAIL arith_retired: got %0d want 10", retired); end
    drain_sb;
  endtask

  task automatic push_fact_expect(input string tag);
    expect_reg({tag, "_r1"}, 0, 1, 32'd0);
    expect_reg({tag, "_r2"}, 0, 2, 32'd5040);
    expect_reg({tag, "_r10"}, 0, 10, 32'd1);
    expect_reg({tag, "_r11"}, 0, 11, 32'd1);
  endtask

  task automatic test_factorial;
    int cyc;
    do_reset;
    load(0, enc_i(OP_ADDI, 1, 0, 7));
    load(1, enc_i(OP_ADDI, 2, 0, 1));
    load(2, enc_r(OP_MUL, 2, 2, 1));
    load(3, enc_i(OP_SUBI, 1, 1, 1));
    load(4, enc_i(OP_BNEQZ, 0, 1, -3));
    load(5, enc_i(OP_ADDI, 10, 10, 1));
    load(6, enc_i(OP_ADDI, 11, 11, 1));
    load(7, {OP_HLT, 26'd0});
    push_fact_expect("fact");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    // a preload write and a second start arrive mid-run and must be ignored
    while (!halted && cyc < 300) begin
      @(negedge clk);
      cyc++;
      ld_en   = (cyc == 10);
      ld_addr = 10'd5;
      ld_data = enc_i(OP_ADDI, 10, 10, 100);
      start   = (cyc == 12);
    end
    ld_en = 1'b0; start = 1'b0;
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL fact_halted: got %b want 1", halted); end
    checks++; if (cyc !== 42) begin errors++; $display("FAIL fact_cycles: got %0d want 42", cyc); end
    checks++; if (retired !== 32'd26) begin errors++; $display("FAIL fact_retired: got %0d want 26", retired); end
    drain_sb;
  endtask

  task automatic test_rst_midrun;
    int cyc;
    do_reset;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    dbg_addr = 5'd2;
    #1;
    checks++; if (retired !== 32'd0) begin errors++; $display("FAIL mid_rst_retired: got %0d want 0", retired); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL mid_rst_running: got %b want 0", running); end
    checks++; if (dbg_data !== 32'd0) begin errors++; $display("FAIL mid_rst_r2: got %h want 0", dbg_data); end
    push_fact_expect("rerun");
    run(0, 300, cyc);
    checks++; if (cyc !== 42) begin errors++; $display("FAIL rerun_cycles: got %0d want 42", cyc); end
    checks++; if (retired !== 32'd26) begin errors++; $display("FAIL rerun_retired: got %0d want 26", retired); end
    drain_sb;
  endtask

  task automatic test_xlen16;
    int cyc;
    do_reset;
    load(0, enc_i(OP_ADDI, 1, 0, -1));
    load(1, enc_i(OP_ADDI, 1, 1, 1));
    load(2, enc_i(OP_ADDI, 2, 0, -1));
    load(3, {OP_HLT, 26'd0});
    expect_reg("x16_r1", 1, 1, 32'd0);
    expect_reg("x16_r2", 1, 2, 32'h0000_FFFF);
    expect_reg("x32_r2", 0, 2, 32'hFFFF_FFFF);
    run(1, 200, cyc);
    checks++; if (halted16 !== 1'b1) begin errors++; $display("FAIL x16_halted: got %b want 1", halted16); end
    checks++; if (retired16 !== 32'd4) begin errors++; $display("FAIL x16_retired: got %0d want 4", retired16); end
    drain_sb;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0; dbg_addr = '0;
    test_reset;
    test_back_to_back;
    test_load_use;
    test_arith;
    test_factorial;
    test_rst_midrun;
    test_xlen16;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_mips_param.md
PIPE_MIPS_PARAM -- requirements
Module: pipe_mips_param

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath and register width.
REQ-002 SHALL have parameter NREG, default 32, register-file entries; only 32 is legal for 5-bit specifiers.
REQ-003 SHALL have parameter MEM_DEPTH, default 1024, words in the unified instruction/data memory.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on posedge clk.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port start, input, 1, one-cycle pulse that begins execution from PC 0.
REQ-007 SHALL have ports ld_en/ld_addr/ld_data, input, 1/clog2(MEM_DEPTH)/32, memory preload write.
REQ-008 SHALL have ports dbg_addr/dbg_data, input/output, 5/XLEN, combinational register-file read.
REQ-009 SHALL have port running, output, 1, high from the cycle after start until halted.
REQ-010 SHALL have port halted, output, 1, high once HLT retires; sticky until rst.
REQ-011 SHALL have port retired, output, 32, count of non-bubble instructions completing WB.

Function
REQ-012 SHALL implement a single-clock 5-stage pipeline (IF, ID, EX, MEM, WB) with the existing opcode map: ADD, SUB, AND, OR, SLT, MUL, ADDI, SUBI, SLTI, LW, SW, beqz, bneqz, HLT.
REQ-013 SHALL use fields opcode[31:26], rs[25:21], rt[20:16], rd[15:11], imm[15:0]; imm sign-extended to XLEN.
REQ-014 SHALL compute all arithmetic modulo 2^XLEN; MUL keeps the low XLEN bits; SLT/SLTI compare signed and yield 0 or 1.
REQ-015 SHALL index memory with the low clog2(MEM_DEPTH) bits of PC or address (wrap-around); data words are the low 32 bits of XLEN zero-extended on load.
REQ-016 SHALL hardwire register 0 to zero; writes to it are discarded.
REQ-017 SHALL write back R-type to rd and I-type/LW to rt; a WB write SHALL be visible to an ID read in the same cycle (write-through).
REQ-018 SHALL forward EX/MEM then MEM/WB results to EX operands, younger source taking priority; no forwarding for rs/rt = 0.
REQ-019 SHALL stall IF and ID one cycle, inserting a bubble into EX, when the ID instruction reads the rt of an LW in EX (load-use).
REQ-020 SHALL resolve branches in EX: target = NPC + imm; beqz taken when A == 0, bneqz when A != 0; taken branch flushes IF/ID and ID/EX (2-cycle penalty), next fetch from target.
REQ-021 SHALL, on HLT or invalid opcode in ID, stop fetching and squash younger instructions; halted rises the cycle HLT completes WB; all older instructions complete.
REQ-022 SHALL perform SW memory writes in MEM; a load in MEM SHALL read memory as it was before any same-cycle write.
REQ-023 SHALL accept ld_en writes only while running = 0; writes while running SHALL be ignored.
REQ-024 SHALL ignore start while running = 1 or halted = 1.
REQ-025 SHALL count retired with wrap at 2^32; bubbles and squashed instructions SHALL not count; HLT counts.

Reset
REQ-026 SHALL on rst set PC = 0, all pipeline registers to bubbles, register file to 0, running = 0, halted = 0, retired = 0.
REQ-027 SHALL retain memory contents across rst; rst mid-run SHALL abort the run with no further memory writes from the aborted run.
REQ-028 SHALL give rst priority over start and ld_en in the same cycle.

Structure
REQ-029 SHALL place opcode constants, type encodings (RR_ALU, RM_ALU, LOAD, STORE, BRANCH, HALT), and field-position constants in shared package mips_pkg.
REQ-030 SHALL place forwarding and load-use detection in one sub-module, mips_hazard_unit; the register file and memory SHALL remain inline.

Verification
REQ-031 SHALL pass: ADDI R1,R0,10; ADDI R2,R0,20; ADD R3,R1,R2; HLT back-to-back -> R3 = 30, retired = 4, no stall cycles.
REQ-032 SHALL pass: preload Mem[120] = 85; ADDI R1,R0,120; LW R2,0(R1); ADDI R3,R2,45; SW R3,1(R1); HLT -> exactly one load-use stall, R3 = 130, Mem[121] = 130.
REQ-033 SHALL pass: factorial loop with N = 7 (MUL, SUBI, bneqz backward) -> product 5040, 2 bubbles per taken branch, instructions after taken branch never write back.
REQ-034 SHALL pass: SLTI R2,R1,0 with R1 = 0xFFFFFFFF -> R2 = 1; ADD overflow 0x7FFFFFFF + 1 -> 0x80000000.
REQ-035 SHALL pass: rst asserted mid-loop then start -> program reruns from PC 0 with unchanged memory image, retired restarts at 0, identical final registers.
REQ-036 SHALL pass: XLEN = 16 build, ADDI R1,R0,-1; ADDI R1,R1,1 -> R1 = 0, halted = 1.
